// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// Holds the receive FSM state enum, data width and synchronizer depth.
package uart_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with extra-bit read/write pointers.
// Ports: clock, reset (async, active-high), push/push_data, pop,
//        head (front byte, 0 when empty), full, empty.
module sync_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // Equal pointers mean empty; equal index with differing wrap bit
    // means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full buffer needs.
    assign push_ok = push && (!full || pop_ok);

    // Head is forced to zero when empty so stale entries never show.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible through head,
    // which is gated by empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a small receive buffer and error pulses.
// Ports: clock, reset (async, active-high), uart_rx (serial in),
//        rx_data/rx_valid/rx_ready (buffer head handshake),
//        frame_err, overflow (one-cycle pulses), busy (FSM not IDLE).
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 51,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    rx_state_t               state;
    logic [CW-1:0]           counter;
    logic [2:0]              index;
    logic [DATA_W-1:0]       shreg;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    rx_s;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;

    // Two-flop synchronizer; idle-high so reset value is 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

    // Push is decided in the same cycle the stop bit is sampled, so
    // the byte is readable the following cycle.
    assign push = (state == STOP) && (counter == '0) && rx_s;
    assign pop  = rx_valid && rx_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            index     <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        counter <= HALF_LOAD;
                    end
                end
                START: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else if (!rx_s) begin
                        state   <= DATA;
                        counter <= FULL_LOAD;
                        index   <= '0;
                    end else begin
                        // Start bit vanished by mid-bit: treat as glitch.
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[DATA_W-1:1]};
                        counter <= FULL_LOAD;
                        if (index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // Absorb a held-low line so a break flags only once.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A good byte that finds the buffer full (and not draining) is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
        end
    end

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (rx_data),
        .full      (full),
        .empty     (empty)
    );

    assign rx_valid = !empty;

endmodule
